rata_mr_monitor: RTL and testbench

Multi-region RATA attestation monitor: the parametrised successor to the single-region AR/LMT watcher. It observes the CPU program counter and the memory write bus, detects writes into any of N_REGIONS attested regions (AR) and into the protected LMT window, and issues timestamped LMT update requests. On any LMT tamper attempt it forces a held system reset that releases only after the CPU has restarted at the reset vector. It sits beside the CPU core, between the core's write port and the LMT memory.

---
 rtl/rata_pkg.sv | 25 ++
 rtl/rata_region_match.sv | 42 ++++
 rtl/rata_mr_monitor.sv | 151 +++++++++++++++
 tb/tb_rata_mr_monitor.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rata_pkg.sv
// rata_pkg: shared definitions for the multi-region RATA attestation monitor.
//   - rata_state_e : monitor FSM state encoding (IDLE/NOTMOD/MOD/RESET)
//   - VIOL_W       : width of the saturating tamper-event counter
//   - in_range()   : inclusive address-window test shared by the matchers
package rata_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    NOTMOD = 2'd1,
    MOD    = 2'd2,
    RESET  = 2'd3
  } rata_state_e;

  localparam int VIOL_W = 8;
  localparam logic [VIOL_W-1:0] VIOL_MAX = {VIOL_W{1'b1}};

  // Operands are widened to 64 bits by the caller so one helper serves
  // every address width up to 64.
  function automatic logic in_range(input logic [63:0] addr,
                                    input logic [63:0] lo,
                                    input logic [63:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/rata_region_match.sv
// rata_region_match: combinational write-address classifier.
// Ports:
//   wen     in   write strobe
//   waddr   in   write address
//   hit     out  write lands in at least one attested region
//   idx     out  lowest-numbered region that was hit (0 when no hit)
//   lmt_hit out  write lands in the protected LMT window
module rata_region_match
  import rata_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int N_REGIONS = 4,
  parameter int IDX_W     = 2,
  parameter logic [N_REGIONS*ADDR_W-1:0] AR_BASE  = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] AR_LIMIT = '0,
  parameter logic [ADDR_W-1:0] LMT_BASE  = '0,
  parameter logic [ADDR_W-1:0] LMT_LIMIT = '0
) (
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic              lmt_hit
);

  // Scan from the highest region down so that the lowest-numbered hit
  // is the last assignment and therefore wins on overlapping regions.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (wen && in_range(64'(waddr),
                          64'(AR_BASE[i*ADDR_W +: ADDR_W]),
                          64'(AR_LIMIT[i*ADDR_W +: ADDR_W]))) begin
        hit = 1'b1;
        idx = IDX_W'(i);
      end
    end
    lmt_hit = wen && in_range(64'(waddr), 64'(LMT_BASE), 64'(LMT_LIMIT));
  end

endmodule

// File: rtl/rata_mr_monitor.sv
// rata_mr_monitor: multi-region RATA attestation monitor.
// Watches the write bus for writes into attested regions (requesting a
// timestamped LMT update) and into the LMT window (forcing a held system
// reset that releases only once the CPU is back at the reset vector).
// Ports:
//   clk, rst   clock (rising edge) and asynchronous active-high reset
//   start      arms the monitor, honoured only in IDLE
//   pc         current program counter
//   wen, waddr memory write strobe and address
//   sys_reset  system reset request (registered)
//   set_lmt    one-cycle LMT update request
//   lmt_idx    region whose LMT entry is updated
//   lmt_ts     timestamp for that LMT entry
//   state      current FSM state
//   viol_cnt   saturating count of LMT tamper events
module rata_mr_monitor
  import rata_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int N_REGIONS = 4,
  parameter int TS_W      = 32,
  parameter logic [N_REGIONS*ADDR_W-1:0] AR_BASE  = '0,
  parameter logic [N_REGIONS*ADDR_W-1:0] AR_LIMIT = '0,
  parameter logic [ADDR_W-1:0] LMT_BASE  = '0,
  parameter logic [ADDR_W-1:0] LMT_LIMIT = '0,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int RST_HOLD  = 4,
  localparam int IDX_W    = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] pc,
  input  logic              wen,
  input  logic [ADDR_W-1:0] waddr,
  output logic              sys_reset,
  output logic              set_lmt,
  output logic [IDX_W-1:0]  lmt_idx,
  output logic [TS_W-1:0]   lmt_ts,
  output logic [1:0]        state,
  output logic [VIOL_W-1:0] viol_cnt
);

  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  logic             ar_hit;
  logic [IDX_W-1:0] ar_idx;
  logic             lmt_hit;

  rata_state_e       state_q,     state_d;
  logic              sys_reset_q, sys_reset_d;
  logic              set_lmt_q,   set_lmt_d;
  logic [IDX_W-1:0]  lmt_idx_q,   lmt_idx_d;
  logic [TS_W-1:0]   lmt_ts_q,    lmt_ts_d;
  logic [TS_W-1:0]   ts_q,        ts_d;
  logic [VIOL_W-1:0] viol_q,      viol_d;
  logic [HOLD_W-1:0] hold_q,      hold_d;

  rata_region_match #(
    .ADDR_W    (ADDR_W),
    .N_REGIONS (N_REGIONS),
    .IDX_W     (IDX_W),
    .AR_BASE   (AR_BASE),
    .AR_LIMIT  (AR_LIMIT),
    .LMT_BASE  (LMT_BASE),
    .LMT_LIMIT (LMT_LIMIT)
  ) u_match (
    .wen     (wen),
    .waddr   (waddr),
    .hit     (ar_hit),
    .idx     (ar_idx),
    .lmt_hit (lmt_hit)
  );

  // Next-state logic. A tamper write always dominates an attested-region
  // write in the same cycle, and every tamper (including repeats while
  // already held in RESET) reloads the hold counter and bumps viol_cnt.
  always_comb begin
    state_d   = state_q;
    set_lmt_d = 1'b0;
    lmt_idx_d = lmt_idx_q;
    lmt_ts_d  = lmt_ts_q;
    viol_d    = viol_q;
    hold_d    = hold_q;
    ts_d      = ts_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (start) state_d = NOTMOD;
      end
      NOTMOD, MOD: begin
        if (lmt_hit) begin
          state_d = RESET;
          hold_d  = HOLD_W'(RST_HOLD);
          viol_d  = (viol_q == VIOL_MAX) ? viol_q : viol_q + 1'b1;
        end else if (ar_hit) begin
          state_d   = MOD;
          set_lmt_d = 1'b1;
          lmt_idx_d = ar_idx;
          lmt_ts_d  = ts_q;
        end else begin
          state_d = NOTMOD;
        end
      end
      RESET: begin
        if (lmt_hit) begin
          hold_d = HOLD_W'(RST_HOLD);
          viol_d = (viol_q == VIOL_MAX) ? viol_q : viol_q + 1'b1;
        end else if ((hold_q == '0) && (pc == RESET_VEC)) begin
          state_d = NOTMOD;
        end else if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // sys_reset is registered alongside state so it tracks RESET exactly.
    sys_reset_d = (state_d == RESET);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sys_reset_q <= 1'b0;
      set_lmt_q   <= 1'b0;
      lmt_idx_q   <= '0;
      lmt_ts_q    <= '0;
      ts_q        <= '0;
      viol_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      sys_reset_q <= sys_reset_d;
      set_lmt_q   <= set_lmt_d;
      lmt_idx_q   <= lmt_idx_d;
      lmt_ts_q    <= lmt_ts_d;
      ts_q        <= ts_d;
      viol_q      <= viol_d;
      hold_q      <= hold_d;
    end
  end

  assign sys_reset = sys_reset_q;
  assign set_lmt   = set_lmt_q;
  assign lmt_idx   = lmt_idx_q;
  assign lmt_ts    = lmt_ts_q;
  assign state     = state_q;
  assign viol_cnt  = viol_q;

endmodule

// File: tb/tb_rata_mr_monitor.sv
// tb_rata_mr_monitor: self-checking bench for rata_mr_monitor.
// Main instance: four overlapping regions plus an LMT window that also
// overlaps region 3. Second instance: one region, 4-bit timestamp, used
// for the timestamp wrap check.
module tb_rata_mr_monitor;

  localparam int ADDR_W   = 32;
  localparam int NREG     = 4;
  localparam int RST_HOLD = 4;
  localparam logic [NREG*ADDR_W-1:0] AR_BASE_P  =
    {32'h0000_2F00, 32'h0000_2000, 32'h0000_1800, 32'h0000_1000};
  localparam logic [NREG*ADDR_W-1:0] AR_LIMIT_P =
    {32'h0000_80FF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_1FFF};
  localparam logic [31:0] LMT_LO  = 32'h0000_8000;
  localparam logic [31:0] LMT_HI  = 32'h0000_80FF;
  localparam logic [31:0] RST_VEC = 32'h0000_0000;

  localparam int M_IDLE = 0, M_NOTMOD = 1, M_MOD = 2, M_RESET = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0, wen = 1'b0;
  logic [31:0] waddr = '0, pc = '0;
  logic        sysReset, setLmt;
  logic [1:0]  lmtIdx, state;
  logic [31:0] lmtTs;
  logic [7:0]  violCnt;

  logic        startW = 1'b0, wenW = 1'b0;
  logic [31:0] waddrW = '0, pcW = '0;
  logic        sysResetW, setLmtW;
  logic [0:0]  lmtIdxW;
  logic [3:0]  lmtTsW;
  logic [1:0]  stateW;
  logic [7:0]  violCntW;

  rata_mr_monitor #(
    .ADDR_W(ADDR_W), .N_REGIONS(NREG), .TS_W(32),
    .AR_BASE(AR_BASE_P), .AR_LIMIT(AR_LIMIT_P),
    .LMT_BASE(LMT_LO), .LMT_LIMIT(LMT_HI),
    .RESET_VEC(RST_VEC), .RST_HOLD(RST_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .wen(wen), .waddr(waddr),
    .sys_reset(sysReset), .set_lmt(setLmt), .lmt_idx(lmtIdx),
    .lmt_ts(lmtTs), .state(state), .viol_cnt(violCnt)
  );

  rata_mr_monitor #(
    .ADDR_W(ADDR_W), .N_REGIONS(1), .TS_W(4),
    .AR_BASE(32'h0000_1000), .AR_LIMIT(32'h0000_1FFF),
    .LMT_BASE(LMT_LO), .LMT_LIMIT(LMT_HI),
    .RESET_VEC(RST_VEC), .RST_HOLD(RST_HOLD)
  ) dutW (
    .clk(clk), .rst(rst), .start(startW), .pc(pcW), .wen(wenW), .waddr(waddrW),
    .sys_reset(sysResetW), .set_lmt(setLmtW), .lmt_idx(lmtIdxW),
    .lmt_ts(lmtTsW), .state(stateW), .viol_cnt(violCntW)
  );

  // Cycles elapsed since reset release; equals the DUT's timestamp.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  int total = 0;
  int bad   = 0;

  int unsigned refBase[NREG]  = '{32'h1000, 32'h1800, 32'h2000, 32'h2F00};
  int unsigned refLimit[NREG] = '{32'h1FFF, 32'h1FFF, 32'h2FFF, 32'h80FF};

  int          mState, mHold, mViol, mIdx;
  logic        mSet;
  logic [31:0] mTs;

  function automatic int findRegion(input logic [31:0] a);
    for (int i = 0; i < NREG; i++)
      if (a >= refBase[i] && a <= refLimit[i]) return i;
    return -1;
  endfunction

  task automatic modelReset();
    mState = M_IDLE; mHold = 0; mViol = 0; mIdx = 0; mSet = 1'b0; mTs = '0;
  endtask

  task automatic modelTamper();
    mState = M_RESET;
    mHold  = RST_HOLD;
    mViol  = (mViol < 255) ? mViol + 1 : 255;
  endtask

  // Reference behaviour, one call per clock edge, from the inputs seen
  // during that cycle and the cycle number (timestamp) of that cycle.
  task automatic modelStep(input logic s, input logic w, input logic [31:0] a,
                           input logic [31:0] p, input logic [31:0] now);
    int   r;
    logic lm;
    r    = w ? findRegion(a) : -1;
    lm   = w && (a >= LMT_LO) && (a <= LMT_HI);
    mSet = 1'b0;
    if (mState == M_IDLE) begin
      if (s) mState = M_NOTMOD;
    end else if (mState == M_RESET) begin
      if (lm) modelTamper();
      else if (mHold == 0 && p == RST_VEC) mState = M_NOTMOD;
      else if (mHold > 0) mHold = mHold - 1;
    end else begin
      if (lm) modelTamper();
      else if (r >= 0) begin
        mState = M_MOD; mSet = 1'b1; mIdx = r; mTs = now;
      end else mState = M_NOTMOD;
    end
  endtask

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("state",     64'(state),    64'(mState));
    cmp("sys_reset", 64'(sysReset), 64'(mState == M_RESET));
    cmp("set_lmt",   64'(setLmt),   64'(mSet));
    cmp("lmt_idx",   64'(lmtIdx),   64'(mIdx));
    cmp("lmt_ts",    64'(lmtTs),    64'(mTs));
    cmp("viol_cnt",  64'(violCnt),  64'(mViol));
  endtask

  task automatic applyStimulus(input logic s, input logic w, input logic [31:0] a,
                               input logic [31:0] p);
    logic [31:0] now;
    @(negedge clk);
    start = s; wen = w; waddr = a; pc = p;
    now = 32'(cyc);
    modelStep(s, w, a, p, now);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    start = 1'b0; wen = 1'b0; waddr = '0; pc = '0;
    startW = 1'b0; wenW = 1'b0; waddrW = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    cmp("rst_state",    64'(state),    64'd0);
    cmp("rst_sysreset", 64'(sysReset), 64'd0);
    cmp("rst_lmt_ts",   64'(lmtTs),    64'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
  endtask

  typedef struct {
    logic        s;
    logic        w;
    logic [31:0] a;
    logic        eSet;
    int          eIdx;
    int          eState;
    logic        eRst;
    int          eViol;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [31:0] wCyc;
    logic [31:0] ra;
    int guard;

    vecs[0]  = '{1'b0, 1'b1, 32'h2010, 1'b0, 0, 0, 1'b0, 0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000, 1'b0, 0, 1, 1'b0, 0};
    vecs[2]  = '{1'b0, 1'b1, 32'h2010, 1'b1, 2, 2, 1'b0, 0};
    vecs[3]  = '{1'b0, 1'b0, 32'h2010, 1'b0, 2, 1, 1'b0, 0};
    vecs[4]  = '{1'b0, 1'b1, 32'h1900, 1'b1, 0, 2, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b1, 32'h1C00, 1'b1, 0, 2, 1'b0, 0};
    vecs[6]  = '{1'b0, 1'b1, 32'h2F10, 1'b1, 2, 2, 1'b0, 0};
    vecs[7]  = '{1'b0, 1'b1, 32'h3000, 1'b1, 3, 2, 1'b0, 0};
    vecs[8]  = '{1'b0, 1'b1, 32'h9000, 1'b0, 3, 1, 1'b0, 0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000, 1'b0, 3, 1, 1'b0, 0};
    vecs[10] = '{1'b0, 1'b1, 32'h8004, 1'b0, 3, 3, 1'b1, 1};

    modelReset();
    doReset();

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].s, vecs[i].w, vecs[i].a, 32'h100);
      cmp($sformatf("vec%0d_set", i),   64'(setLmt),   64'(vecs[i].eSet));
      cmp($sformatf("vec%0d_idx", i),   64'(lmtIdx),   64'(vecs[i].eIdx));
      cmp($sformatf("vec%0d_state", i), 64'(state),    64'(vecs[i].eState));
      cmp($sformatf("vec%0d_rst", i),   64'(sysReset), 64'(vecs[i].eRst));
      cmp($sformatf("vec%0d_viol", i),  64'(violCnt),  64'(vecs[i].eViol));
    end

    // Hold count runs out, then pc at the reset vector releases the hold.
    for (int i = 0; i < RST_HOLD; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, RST_VEC);
      cmp("hold_sysreset", 64'(sysReset), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, RST_VEC);
    cmp("release_state", 64'(state), 64'(M_NOTMOD));
    cmp("release_sysreset", 64'(sysReset), 64'd0);

    // Held reset while the CPU never returns to the reset vector.
    applyStimulus(1'b0, 1'b1, 32'h8004, 32'h100);
    cmp("tamper2_viol", 64'(violCnt), 64'd2);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h100);
      cmp("held_sysreset", 64'(sysReset), 64'd1);
    end
    // Repeated tamper inside RESET restarts the full hold.
    applyStimulus(1'b0, 1'b1, 32'h80FF, RST_VEC);
    cmp("tamper3_viol", 64'(violCnt), 64'd3);
    for (int i = 0; i < RST_HOLD; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, RST_VEC);
      cmp("rehold_sysreset", 64'(sysReset), 64'd1);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, RST_VEC);
    cmp("rehold_release", 64'(state), 64'(M_NOTMOD));

    // Asynchronous reset in the middle of a held reset.
    applyStimulus(1'b0, 1'b1, 32'h8000, 32'h100);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h100);
    #2;
    rst = 1'b1;
    #1;
    cmp("async_state",    64'(state),    64'd0);
    cmp("async_sysreset", 64'(sysReset), 64'd0);
    cmp("async_set_lmt",  64'(setLmt),   64'd0);
    cmp("async_lmt_idx",  64'(lmtIdx),   64'd0);
    cmp("async_lmt_ts",   64'(lmtTs),    64'd0);
    cmp("async_viol",     64'(violCnt),  64'd0);
    start = 1'b0; wen = 1'b0; pc = '0;
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    applyStimulus(1'b0, 1'b1, 32'h2010, 32'h100);
    cmp("unarmed_set_lmt", 64'(setLmt), 64'd0);

    // Randomised traffic against the reference model.
    doReset();
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0: ra = 32'h1000 + $urandom_range(0, 32'hFFF);
        1: ra = 32'h1800 + $urandom_range(0, 32'h7FF);
        2: ra = 32'h2000 + $urandom_range(0, 32'hFFF);
        3: ra = 32'h2F00 + $urandom_range(0, 32'h1FF);
        4: ra = ($urandom_range(0, 15) == 0) ? 32'h8000 + $urandom_range(0, 32'h1FF)
                                              : 32'h7F00 + $urandom_range(0, 32'hFF);
        5: begin
          case ($urandom_range(0, 5))
            0: ra = 32'h0FFF;
            1: ra = 32'h1000;
            2: ra = 32'h2FFF;
            3: ra = 32'h80FF;
            4: ra = 32'h8100;
            default: ra = 32'h7FFF;
          endcase
        end
        default: ra = $urandom;
      endcase
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0, ra,
                    ($urandom_range(0, 2) == 0) ? RST_VEC : 32'($urandom));
    end

    // Timestamp wrap on the 4-bit instance.
    doReset();
    startW = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h100);
    startW = 1'b0;
    guard = 0;
    while (cyc != 17 && guard < 100) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h100);
      guard++;
    end
    if (guard >= 100) begin
      total++; bad++;
      $display("[TB] FAIL wrap_timeout: cyc=%0d required 17", cyc);
    end
    wenW = 1'b1; waddrW = 32'h1004;
    wCyc = 32'(cyc);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h100);
    wenW = 1'b0;
    cmp("wrap_set_lmt", 64'(setLmtW), 64'd1);
    cmp("wrap_lmt_ts",  64'(lmtTsW),  64'(wCyc % 16));
    cmp("wrap_lmt_idx", 64'(lmtIdxW), 64'd0);
    cmp("wrap_state",   64'(stateW),  64'(M_MOD));

    // viol_cnt saturation.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h100);
    for (int i = 0; i < 300; i++)
      applyStimulus(1'b0, 1'b1, 32'h8010, 32'h100);
    cmp("sat_viol", 64'(violCnt), 64'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
